// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, XZR index, stage-control bundle.
// Pure declarations; no logic, no latency.
package cpu_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, MULTI = 1'b1} hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the ID sources and a load in EX; purely combinational, zero latency.
// XZR as destination never matches.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use_hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit      = id_use1 && (id_rs1 == ex_rd);
  assign rs2_hit      = id_use2 && (id_rs2 == ex_rd);
  assign load_use_hit = ex_mem_read && (ex_rd != XZR) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are same-cycle combinational,
// mem_busy freezes everything upstream of MEM/WB and defers all other events.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_multi_start,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [3:0] CNT_LOAD = 4'(MULTI_LAT - 2);

  hz_state_t   state;
  hz_state_t   state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        load_use_hit;
  stage_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .load_use_hit (load_use_hit)
  );

  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (reset) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (mem_busy) begin
      // EX is frozen, so deferred branch/multi/load-use inputs are still valid after release
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_en    = 1'b0;
      ctrl.memwb_flush = 1'b1;
    end else if (state == MULTI) begin
      if (cnt != 4'd0) begin
        ctrl.pc_en       = 1'b0;
        ctrl.ifid_en     = 1'b0;
        ctrl.idex_en     = 1'b0;
        ctrl.exmem_flush = 1'b1;
        cnt_nxt          = cnt - 4'd1;
      end else begin
        state_nxt = RUN;
      end
    end else if (ex_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (ex_multi_start) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_flush = 1'b1;
      state_nxt        = MULTI;
      cnt_nxt          = CNT_LOAD;
    end else if (load_use_hit) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!ctrl.pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed cases plus randomized traffic against a cycle-level reference model.
// A second 4-bit-counter instance shares the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use1, id_use2, ex_mem_read, ex_multi_start, ex_branch_taken, mem_busy;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [31:0] stall_cycles;
  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush;
  logic [3:0]  stall_cycles4;

  pipe_hazard_ctrl #(.MULTI_LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1),
    .id_use2(id_use2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_multi_start(ex_multi_start), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MULTI_LAT(LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1),
    .id_use2(id_use2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_multi_start(ex_multi_start), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .stall_cycles(stall_cycles4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of stalled cycles already spent on the current multi-cycle op
  // (0 = none in flight), plus unbounded stall counts clamped to each counter width.
  int      m_op   = 0;
  longint  m_cnt  = 0;
  longint  m_cnt4 = 0;

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(ex_branch_taken && ex_multi_start))
        else $error("FAIL illegal_branch_and_multi both high");
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle: inputs already set; compare at negedge, then advance the model.
  task automatic step(input string tag);
    logic [8:0] exp;
    logic [8:0] got;
    logic [8:0] got_s;
    bit         lu;
    @(negedge clk);
    lu = ex_mem_read && (ex_rd != 5'd31) &&
         ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
    // order: pc ifid idex exmem memwb enables, then ifid idex exmem memwb flushes
    exp = 9'b11111_0000;
    if (reset)                 exp = 9'b11111_0000;
    else if (mem_busy)         exp = 9'b00001_0001;
    else if (m_op > 0)         exp = (m_op < LAT - 1) ? 9'b00011_0010 : 9'b11111_0000;
    else if (ex_branch_taken)  exp = 9'b11111_1100;
    else if (ex_multi_start)   exp = 9'b00011_0010;
    else if (lu)               exp = 9'b00111_0100;
    got   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush};
    got_s = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
             s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush};
    chk({tag, "_ctrl"}, 64'(got), 64'(exp));
    chk({tag, "_ctrl4"}, 64'(got_s), 64'(exp));
    chk({tag, "_cnt"}, 64'(stall_cycles), 64'(m_cnt));
    chk({tag, "_cnt4"}, 64'(stall_cycles4), 64'(m_cnt4));
    if (reset) begin
      m_op = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (!exp[8]) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (!mem_busy) begin
        if (m_op > 0)                                  m_op = (m_op < LAT - 1) ? m_op + 1 : 0;
        else if (!ex_branch_taken && ex_multi_start)   m_op = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_multi_start = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // 1: load-use on rs1
    ex_rd = 5'd3; ex_mem_read = 1'b1; id_rs1 = 5'd3; id_use1 = 1'b1;
    step("lu_rs1");
    chk("lu_count", 64'(stall_cycles), 64'd1);
    idle_inputs();
    step("lu_clear");

    // 2: XZR destination and unused source never stall
    ex_rd = 5'd31; ex_mem_read = 1'b1; id_rs1 = 5'd31; id_use1 = 1'b1;
    step("lu_xzr");
    ex_rd = 5'd3; id_rs1 = 5'd3; id_use1 = 1'b0;
    step("lu_nouse");
    chk("lu_nostall_count", 64'(stall_cycles), 64'd1);
    idle_inputs();

    // 3: multi-cycle op held 4 cycles
    ex_multi_start = 1'b1;
    for (int i = 0; i < LAT; i++) step("multi");
    ex_multi_start = 1'b0;
    chk("multi_count", 64'(stall_cycles), 64'd4);
    step("multi_after");

    // 4: branch masks a load-use hit
    ex_branch_taken = 1'b1; ex_rd = 5'd7; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_use2 = 1'b1;
    step("br_lu");
    chk("br_count", 64'(stall_cycles), 64'd4);
    idle_inputs();

    // 5: mem_busy while MULTI has cnt==1
    ex_multi_start = 1'b1;
    step("mb_m0");
    step("mb_m1");
    mem_busy = 1'b1;
    step("mb_busy0");
    step("mb_busy1");
    mem_busy = 1'b0;
    step("mb_m2");
    step("mb_release");
    ex_multi_start = 1'b0;
    chk("mb_count", 64'(stall_cycles), 64'd9);

    // 6: reset inside MULTI
    ex_multi_start = 1'b1;
    step("rm_m0");
    step("rm_m1");
    reset = 1'b1;
    step("rm_reset");
    reset = 1'b0; ex_multi_start = 1'b0;
    chk("rm_count", 64'(stall_cycles), 64'd0);
    step("rm_run");

    // saturation of the narrow counter
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    mem_busy = 1'b0;
    chk("sat_count4", 64'(stall_cycles4), 64'hF);
    chk("sat_count32", 64'(stall_cycles), 64'd20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      id_rs1   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      id_rs2   = 5'($urandom_range(0, 3));
      id_use1  = 1'($urandom);
      id_use2  = 1'($urandom);
      ex_rd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom);
      if (m_op > 0) begin
        ex_multi_start  = 1'b1;
        ex_branch_taken = 1'b0;
      end else begin
        ex_multi_start  = ($urandom_range(0, 9) == 0);
        ex_branch_taken = !ex_multi_start && ($urandom_range(0, 7) == 0);
      end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
